// File: rtl/pipelined_universal_shifter_if.sv
// ---------------------------------------------------------------------------
// pipelined_universal_shifter_if
//
// Purpose: bundles the operand-side and result-side valid/ready handshakes of
// the pipelined universal shifter into one interface.
//
// Signals:
//   in_valid / in_ready          operand handshake
//   in_data  [WIDTH-1:0]         operand
//   in_shamt [SHW-1:0]           shift amount, 0..WIDTH-1
//   in_dir                       0 = right, 1 = left
//   in_mode  [1:0]               00 logical, 01 arithmetic, 10 rotate, 11 logical
//   out_valid / out_ready        result handshake
//   out_data [WIDTH-1:0]         shifted result
//   out_sticky                   OR of bits dropped by a right logical or
//                                arithmetic shift (only with SHIFTER_STICKY_EN)
//
// Modports:
//   master  operand source / result consumer side
//   slave   the shifter itself
//
// Optional feature macro: SHIFTER_STICKY_EN
// ---------------------------------------------------------------------------
interface pipelined_universal_shifter_if #(
    parameter int WIDTH = 16
) ();
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic             in_dir;
    logic [1:0]       in_mode;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef SHIFTER_STICKY_EN
    logic             out_sticky;
`endif

    modport master (
        output in_valid, in_data, in_shamt, in_dir, in_mode, out_ready,
`ifdef SHIFTER_STICKY_EN
        input  out_sticky,
`endif
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_dir, in_mode, out_ready,
`ifdef SHIFTER_STICKY_EN
        output out_sticky,
`endif
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipelined_universal_shifter.sv
// ---------------------------------------------------------------------------
// pipelined_universal_shifter
//
// Purpose: WIDTH-bit logical / arithmetic / rotate shifter, left or right,
// built as a log shifter with one mux level per pipeline stage. Stage k
// shifts by 2^k when bit k of the shift amount is set. Valid/ready
// handshake on both sides with full backpressure; bubbles collapse and a
// full pipe holds SHW items. Throughput is one result per cycle.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset (discards all in-flight items)
//   bus   pipelined_universal_shifter_if.slave (operand + result handshakes)
//
// Parameters:
//   WIDTH operand width, power of 2 and >= 4 (must match the interface)
//
// Optional feature macro: SHIFTER_STICKY_EN
//   When defined, every stage also carries a sticky bit collecting the OR of
//   all bits dropped by right logical/arithmetic shifts; it is presented on
//   bus.out_sticky aligned with out_data.
// ---------------------------------------------------------------------------
module pipelined_universal_shifter #(
    parameter int WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    pipelined_universal_shifter_if.slave    bus
);
    localparam int SHW = $clog2(WIDTH);

    // Stage registers. Control fields are only needed by a following stage,
    // so the last stage keeps data and valid (and sticky) only.
    logic [SHW-1:0]   valid_q;
    logic [WIDTH-1:0] data_q  [SHW];
    logic [SHW-1:0]   shamt_q [SHW-1];
    logic             dir_q   [SHW-1];
    logic [1:0]       mode_q  [SHW-1];

    // Values presented to each stage's mux level this cycle.
    logic [SHW-1:0]   stg_valid;
    logic [WIDTH-1:0] stg_data  [SHW];
    logic [SHW-1:0]   stg_shamt [SHW];
    logic             stg_dir   [SHW];
    logic [1:0]       stg_mode  [SHW];

    logic [WIDTH-1:0] shifted   [SHW];
    logic [SHW-1:0]   load;

`ifdef SHIFTER_STICKY_EN
    logic [SHW-1:0]   sticky_q;
    logic [SHW-1:0]   stg_sticky;
    logic [SHW-1:0]   dropped;
`endif

    // Stage 0 is fed from the operand port; every later stage is fed from
    // the register of the stage before it.
    always_comb begin
        stg_valid[0] = bus.in_valid;
        stg_data[0]  = bus.in_data;
        stg_shamt[0] = bus.in_shamt;
        stg_dir[0]   = bus.in_dir;
        stg_mode[0]  = bus.in_mode;
        for (int k = 1; k < SHW; k++) begin
            stg_valid[k] = valid_q[k-1];
            stg_data[k]  = data_q[k-1];
            stg_shamt[k] = shamt_q[k-1];
            stg_dir[k]   = dir_q[k-1];
            stg_mode[k]  = mode_q[k-1];
        end
    end

`ifdef SHIFTER_STICKY_EN
    // Sticky accumulates along the pipe; stage 0 starts from a clean zero.
    always_comb begin
        stg_sticky[0] = 1'b0;
        for (int k = 1; k < SHW; k++) begin
            stg_sticky[k] = sticky_q[k-1];
        end
    end
`endif

    // One log-shifter level per stage. Arithmetic right fills with the
    // current MSB, which earlier right-arithmetic levels have preserved as
    // the operand's sign. Mode 11 falls into the logical default arms.
    always_comb begin
        for (int k = 0; k < SHW; k++) begin
            shifted[k] = stg_data[k];
`ifdef SHIFTER_STICKY_EN
            dropped[k] = 1'b0;
`endif
            if (stg_shamt[k][k]) begin
                if (stg_dir[k]) begin
                    if (stg_mode[k] == 2'b10) begin
                        shifted[k] = (stg_data[k] << (1 << k))
                                   | (stg_data[k] >> (WIDTH - (1 << k)));
                    end else begin
                        shifted[k] = stg_data[k] << (1 << k);
                    end
                end else begin
                    case (stg_mode[k])
                        2'b01: shifted[k] = $signed(stg_data[k]) >>> (1 << k);
                        2'b10: shifted[k] = (stg_data[k] >> (1 << k))
                                          | (stg_data[k] << (WIDTH - (1 << k)));
                        default: shifted[k] = stg_data[k] >> (1 << k);
                    endcase
`ifdef SHIFTER_STICKY_EN
                    if (stg_mode[k] != 2'b10) begin
                        dropped[k] = |(stg_data[k] & ~({WIDTH{1'b1}} << (1 << k)));
                    end
`endif
                end
            end
        end
    end

    // Advance chain: a stage loads when it is empty or its successor loads.
    // This makes in_ready combinational from out_ready through every stage,
    // which is what lets bubbles collapse and gives full-rate throughput.
    always_comb begin
        load[SHW-1] = !valid_q[SHW-1] || bus.out_ready;
        for (int k = SHW - 2; k >= 0; k--) begin
            load[k] = !valid_q[k] || load[k+1];
        end
    end

    // Stage registers. Data and control only move when a real item enters a
    // stage, so a bubble never disturbs what the output is showing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < SHW; k++) begin
                data_q[k] <= '0;
            end
            for (int k = 0; k < SHW - 1; k++) begin
                shamt_q[k] <= '0;
                dir_q[k]   <= 1'b0;
                mode_q[k]  <= 2'b00;
            end
        end else begin
            for (int k = 0; k < SHW; k++) begin
                if (load[k]) begin
                    valid_q[k] <= stg_valid[k];
                    if (stg_valid[k]) begin
                        data_q[k] <= shifted[k];
                    end
                end
            end
            for (int k = 0; k < SHW - 1; k++) begin
                if (load[k] && stg_valid[k]) begin
                    shamt_q[k] <= stg_shamt[k];
                    dir_q[k]   <= stg_dir[k];
                    mode_q[k]  <= stg_mode[k];
                end
            end
        end
    end

`ifdef SHIFTER_STICKY_EN
    // Sticky flops follow exactly the same load rule as the data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= '0;
        end else begin
            for (int k = 0; k < SHW; k++) begin
                if (load[k] && stg_valid[k]) begin
                    sticky_q[k] <= stg_sticky[k] | dropped[k];
                end
            end
        end
    end

    assign bus.out_sticky = sticky_q[SHW-1];
`endif

    assign bus.in_ready  = load[0];
    assign bus.out_valid = valid_q[SHW-1];
    assign bus.out_data  = data_q[SHW-1];

endmodule

// File: tb/tb_pipelined_universal_shifter.sv
// ---------------------------------------------------------------------------
// tb_pipelined_universal_shifter
//
// Directed scoreboard bench for pipelined_universal_shifter (WIDTH = 16).
// The driver pushes the hand-computed result of every accepted operand into
// a queue; an independent monitor pops and compares on each output transfer.
// Sticky results are compared when SHIFTER_STICKY_EN is defined.
// ---------------------------------------------------------------------------
module tb_pipelined_universal_shifter;
    localparam int WIDTH = 16;
    localparam int SHW   = 4;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             sticky;
        int               accept_cycle;
        bit               check_latency;
        string            name;
    } exp_t;

    exp_t  sb[$];
    exp_t  mon_e;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    checks = 0;
    int    errors = 0;
    int    cycle  = 0;

    pipelined_universal_shifter_if #(.WIDTH(WIDTH)) bus ();

    pipelined_universal_shifter #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10 ns clock; cycle counts rising edges seen so far.
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Generic comparison: one FAIL line per mismatch.
    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Called just after a falling edge; offers one operand until accepted
    // (bounded), records the expected result, returns after the next
    // falling edge with in_valid still high so calls can run back-to-back.
    task automatic applyStimulus(input string name, input logic [15:0] data,
                                 input logic [3:0] shamt, input logic dir,
                                 input logic [1:0] mode, input logic [15:0] exp_data,
                                 input logic exp_sticky, input bit chk_lat);
        bit acc;
        int waited;
        acc    = 1'b0;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_shamt = shamt;
        bus.in_dir   = dir;
        bus.in_mode  = mode;
        while (!acc && waited < 50) begin
            #1;
            acc = bus.in_ready;
            @(posedge clk);
            if (!acc) begin
                waited++;
                @(negedge clk);
            end
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s accept timeout: got in_ready 0, expected 1", name);
            bus.in_valid = 1'b0;
            return;
        end
        #1;
        sb.push_back('{exp_data, exp_sticky, cycle, chk_lat, name});
        @(negedge clk);
    endtask

    // Wait (bounded) for every expected result to come out.
    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_drain_pending"}, 32'(sb.size()), 32'd0);
    endtask

    // Monitor: samples mid-low-phase; an output transfer happens at the next
    // rising edge whenever out_valid and out_ready are both high here.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output: got %h, expected no output", bus.out_data);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput({mon_e.name, "_data"}, 32'(bus.out_data), 32'(mon_e.data));
`ifdef SHIFTER_STICKY_EN
                    checkOutput({mon_e.name, "_sticky"}, 32'(bus.out_sticky), 32'(mon_e.sticky));
`endif
                    if (mon_e.check_latency) begin
                        checkOutput({mon_e.name, "_latency"}, 32'(cycle + 1 - mon_e.accept_cycle), 32'(SHW));
                    end
                end
            end
        end
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_shamt  = '0;
        bus.in_dir    = 1'b0;
        bus.in_mode   = 2'b00;
        bus.out_ready = 1'b0;
        rst           = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_out_data", 32'(bus.out_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);

        // Single operand into an empty pipe: also checks latency.
        applyStimulus("shl3", 16'hB252, 4'd3, 1'b1, 2'b00, 16'h9290, 1'b0, 1'b1);
        bus.in_valid = 1'b0;
        bus.in_data  = 16'hDEAD;
        waitDrain("shl3");

        // Back-to-back directed vectors.
        applyStimulus("rotl3",     16'hB252, 4'd3,  1'b1, 2'b10, 16'h9295, 1'b0, 1'b0);
        applyStimulus("rotr4",     16'hB252, 4'd4,  1'b0, 2'b10, 16'h2B25, 1'b0, 1'b0);
        applyStimulus("asr4",      16'hB252, 4'd4,  1'b0, 2'b01, 16'hFB25, 1'b1, 1'b0);
        applyStimulus("lsr4",      16'hB252, 4'd4,  1'b0, 2'b00, 16'h0B25, 1'b1, 1'b0);
        applyStimulus("m11sr4",    16'hB252, 4'd4,  1'b0, 2'b11, 16'h0B25, 1'b1, 1'b0);
        applyStimulus("lsr1",      16'hB252, 4'd1,  1'b0, 2'b00, 16'h5929, 1'b0, 1'b0);
        applyStimulus("zero_lsr",  16'hB252, 4'd0,  1'b0, 2'b00, 16'hB252, 1'b0, 1'b0);
        applyStimulus("zero_asr",  16'hB252, 4'd0,  1'b0, 2'b01, 16'hB252, 1'b0, 1'b0);
        applyStimulus("zero_rotl", 16'hB252, 4'd0,  1'b1, 2'b10, 16'hB252, 1'b0, 1'b0);
        applyStimulus("zero_m11l", 16'hB252, 4'd0,  1'b1, 2'b11, 16'hB252, 1'b0, 1'b0);
        applyStimulus("lsr15",     16'h8001, 4'd15, 1'b0, 2'b00, 16'h0001, 1'b1, 1'b0);
        applyStimulus("shl15",     16'h0001, 4'd15, 1'b1, 2'b00, 16'h8000, 1'b0, 1'b0);
        applyStimulus("rotr15",    16'h0001, 4'd15, 1'b0, 2'b10, 16'h0002, 1'b0, 1'b0);
        applyStimulus("asr15",     16'h8000, 4'd15, 1'b0, 2'b01, 16'hFFFF, 1'b0, 1'b0);
        applyStimulus("asr4_pos",  16'h7FF0, 4'd4,  1'b0, 2'b01, 16'h07FF, 1'b0, 1'b0);
        applyStimulus("asl3",      16'hB252, 4'd3,  1'b1, 2'b01, 16'h9290, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        bus.in_data  = 16'h5A5A;
        bus.in_shamt = 4'd7;
        waitDrain("directed");

        // Backpressure: pipe fills to SHW items then stalls with data held.
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus($sformatf("bp_%0d", i), 16'(i), 4'd1, 1'b1, 2'b00, 16'(2 * i), 1'b0, 1'b0);
        end
        bus.in_data  = 16'd5;
        bus.in_valid = 1'b1;
        #1;
        checkOutput("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkOutput("bp_hold_out_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("bp_hold_out_data", 32'(bus.out_data), 32'h0002);
            checkOutput("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        applyStimulus("bp_5", 16'd5, 4'd1, 1'b1, 2'b00, 16'd10, 1'b0, 1'b0);
        applyStimulus("bp_6", 16'd6, 4'd1, 1'b1, 2'b00, 16'd12, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        waitDrain("bp");

        // Reset with three items in flight.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus($sformatf("flush_%0d", i), 16'h00F0, 4'd0, 1'b0, 2'b00, 16'h00F0, 1'b0, 1'b0);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("flush_pre_out_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("flush_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("flush_out_data", 32'(bus.out_data), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        checkOutput("flush_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (10) @(negedge clk);
        #1;
        checkOutput("flush_no_stale", 32'(bus.out_valid), 32'd0);

        // Pipe still works after the flush.
        @(negedge clk);
        applyStimulus("post_rst", 16'hB252, 4'd3, 1'b1, 2'b00, 16'h9290, 1'b0, 1'b1);
        bus.in_valid = 1'b0;
        waitDrain("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
